cam_pixel_capture: RTL

- Downstream of the OV7670 SCCB configuration block; runs once configuration completes.
- Samples the camera's parallel bus (pclk, vsync, href, data[7:0]) in the system clock domain.
- Assembles RGB444 "RG BX" byte pairs into 12-bit pixels.
- Emits one write strobe per pixel with a linear frame-buffer address, plus frame-level status.

---
 rtl/cam_pixel_capture_if.sv | 23 ++
 rtl/cam_pixel_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_capture_if.sv
// Camera parallel bus plus pixel write bus, shared between the capture block
// and its environment (sensor model / frame buffer).
interface cam_pixel_capture_if #(
   parameter int ADDR_W = 19
);
   logic              cmos_pclk;
   logic              cmos_vsync;
   logic              cmos_href;
   logic [7:0]        cmos_data;
   logic              pix_valid;
   logic [11:0]       pix_data;
   logic [ADDR_W-1:0] pix_addr;

   modport master (
      output cmos_pclk, cmos_vsync, cmos_href, cmos_data,
      input  pix_valid, pix_data, pix_addr
   );

   modport slave (
      input  cmos_pclk, cmos_vsync, cmos_href, cmos_data,
      output pix_valid, pix_data, pix_addr
   );
endinterface

// File: rtl/cam_pixel_capture.sv
// OV7670 RGB444 capture: synchronizes the camera bus into clk, pairs bytes into
// 12-bit pixels and emits linear frame-buffer writes with frame status.
module cam_pixel_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int ADDR_W      = 19,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_done,
   cam_pixel_capture_if.slave  bus,
   output logic                frame_done,
   output logic                frame_short,
   output logic [1:0]          state
);
   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, CAPTURE = 2'd2} state_t;

   logic [SYNC_STAGES-1:0][10:0] sync_q;
   logic [10:0]  s_bus;
   logic [2:0]   dly_q;
   logic         rise_p1, hfall_p1, vrise_p1, vfall_p1, href_p1;
   logic [7:0]   data_p1;

   state_t            state_q, state_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d, padr_q, padr_d, pix_addr_q;
   logic              phase_q, phase_d, pend_q, pend_d, fd_q, fd_d, shrt_q, shrt_d;
   logic [7:0]        byte_q, byte_d;
   logic [11:0]       pdat_q, pdat_d, pix_data_q;
   logic              pix_valid_q, frame_done_q, frame_short_q;

   // All four camera signals share one chain so byte, href and pclk stay aligned.
   assign s_bus = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         dly_q    <= '0;
         rise_p1  <= 1'b0;
         hfall_p1 <= 1'b0;
         vrise_p1 <= 1'b0;
         vfall_p1 <= 1'b0;
         href_p1  <= 1'b0;
         data_p1  <= '0;
      end else begin
         sync_q[0] <= {bus.cmos_pclk, bus.cmos_vsync, bus.cmos_href, bus.cmos_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         dly_q    <= s_bus[10:8];
         rise_p1  <= s_bus[10] & ~dly_q[2];
         vrise_p1 <= s_bus[9]  & ~dly_q[1];
         vfall_p1 <= ~s_bus[9] &  dly_q[1];
         hfall_p1 <= ~s_bus[8] &  dly_q[0];
         href_p1  <= s_bus[8];
         data_p1  <= s_bus[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         addr_q        <= '0;
         phase_q       <= 1'b0;
         byte_q        <= '0;
         pend_q        <= 1'b0;
         pdat_q        <= '0;
         padr_q        <= '0;
         fd_q          <= 1'b0;
         shrt_q        <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= '0;
         pix_addr_q    <= '0;
         frame_done_q  <= 1'b0;
         frame_short_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         addr_q        <= addr_d;
         phase_q       <= phase_d;
         byte_q        <= byte_d;
         pend_q        <= pend_d;
         pdat_q        <= pdat_d;
         padr_q        <= padr_d;
         fd_q          <= fd_d;
         shrt_q        <= shrt_d;
         pix_valid_q   <= pend_q & cfg_done;
         if (pend_q && cfg_done) begin
            pix_data_q <= pdat_q;
            pix_addr_q <= padr_q;
         end
         frame_done_q  <= fd_q;
         frame_short_q <= frame_short_q | (fd_q & shrt_q);
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      byte_d  = byte_q;
      pend_d  = 1'b0;
      pdat_d  = pdat_q;
      padr_d  = padr_q;
      fd_d    = 1'b0;
      shrt_d  = 1'b0;
      if (!cfg_done) begin
         state_d = IDLE;
         phase_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = WAIT_FRAME;
            WAIT_FRAME: begin
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               phase_d = 1'b0;
               if (vfall_p1) state_d = CAPTURE;
            end
            CAPTURE: begin
               // Line end wins over a coincident byte; addr jumps to the next line start.
               if (hfall_p1) begin
                  if (x_q != '0) begin
                     y_d    = (y_q == YW'(V_ACTIVE)) ? y_q : y_q + 1'b1;
                     addr_d = addr_q + (ADDR_W'(H_ACTIVE) - ADDR_W'(x_q));
                  end
                  x_d     = '0;
                  phase_d = 1'b0;
               end else if (rise_p1 && href_p1) begin
                  if (!phase_q) begin
                     byte_d  = data_p1;
                     phase_d = 1'b1;
                  end else begin
                     if (x_q < XW'(H_ACTIVE) && y_q < YW'(V_ACTIVE)) begin
                        pend_d = 1'b1;
                        pdat_d = {byte_q, data_p1[7:4]};
                        padr_d = addr_q;
                        addr_d = addr_q + 1'b1;
                     end
                     if (x_q != XW'(H_ACTIVE)) x_d = x_q + 1'b1;
                     phase_d = 1'b0;
                  end
               end
               if (vrise_p1) begin
                  fd_d    = 1'b1;
                  shrt_d  = (y_d < YW'(V_ACTIVE));
                  state_d = WAIT_FRAME;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_data  = pix_data_q;
   assign bus.pix_addr  = pix_addr_q;
   assign frame_done    = frame_done_q;
   assign frame_short   = frame_short_q;
   assign state         = state_q;
endmodule
